pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Merges four sources into per-stage write enables, bubble flushes and the PC redirect:
  - load-use/branch-operand stall from ID hazard detection
  - taken-branch/jump redirect from EX
  - instruction-memory (AXI IM wrapper) wait
  - data-memory (AXI DM wrapper) wait
- Sequences redirects that collide with an in-flight, non-cancellable AXI instruction fetch.

Parameters:
- ADDR_W, 32, PC/target width.
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hz_stall  in  1  ID hazard stall request (level)
- br_taken  in  1  EX taken branch/jal/jalr (level; EX holds it while frozen)
- br_target  in  ADDR_W  EX redirect target
- im_stall  in  1  IM fetch busy; when low, fetch data is valid and held until pc_write
- dm_stall  in  1  DM access busy
- pc_write  out  1  PC register enable
- pc_redirect  out  1  PC mux selects pc_redirect_addr
- pc_redirect_addr  out  ADDR_W  redirect address
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID loads bubble
- id_ex_write  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX loads bubble
- ex_mem_write  out  1  EX/MEM enable
- mem_wb_write  out  1  MEM/WB enable
- drop_pend  out  1  a redirect is waiting on an in-flight fetch

Behaviour:
- State registers:
  - fsm: RUN or DROP.
  - pend_addr: ADDR_W bits.
- Reset (async, active-high):
  - fsm=RUN, pend_addr=0.
  - While rst=1, all enables, flushes and pc_redirect are 0; pc_redirect_addr=0; drop_pend=0.
  - A reset during DROP abandons the pending redirect.
- All outputs are combinational from the state and the current inputs. fsm/pend_addr update on the clk rising edge.
- Priority 1, dm_stall=1 (full freeze):
  - All *_write=0, all flushes=0, pc_redirect=0.
  - fsm and pend_addr hold; br_taken and hz_stall are ignored this cycle.
- Otherwise ex_mem_write=1 and mem_wb_write=1.
- Priority 2, br_taken=1 (fsm=RUN):
  - if_id_flush=1, id_ex_flush=1, if_id_write=1, id_ex_write=1.
  - The branch overrides hz_stall, because the stalled instruction is younger.
  - If im_stall=0: pc_write=1, pc_redirect=1, pc_redirect_addr=br_target.
  - If im_stall=1: pc_write=0, pend_addr<=br_target, fsm<=DROP.
- Priority 3, hz_stall=1:
  - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1 (bubble into EX).
  - This overrides the im_stall IF/ID rule, so IF/ID holds.
- Priority 4, im_stall=1 (no hz_stall):
  - pc_write=0, if_id_write=1, if_id_flush=1 (bubble into ID).
  - id_ex_write=1.
- Default: every write enable=1, every flush=0.
- DROP state:
  - drop_pend=1.
  - Every cycle with dm_stall=0: if_id_flush=1, if_id_write=1, id_ex_write=1.
  - While im_stall=1: pc_write=0 and fsm stays DROP.
  - First cycle with im_stall=0 and dm_stall=0: the returned (stale) instruction is discarded via if_id_flush=1; pc_write=1, pc_redirect=1, pc_redirect_addr=pend_addr; fsm<=RUN.
  - If im_stall falls while dm_stall=1: stay in DROP and complete on the first unfrozen cycle.
  - br_taken in DROP (defensive): pend_addr<=br_target, id_ex_flush=1, remain in DROP.
  - hz_stall is ignored in DROP.
- pc_redirect_addr=pend_addr whenever fsm=DROP, otherwise br_target.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, three extra output ports, each CNT_W wide:
  - perf_dm_cyc: counts cycles with dm_stall=1.
  - perf_im_cyc: counts cycles with im_stall=1 and dm_stall=0.
  - perf_redirect: counts cycles with pc_redirect=1.
- Counter rules:
  - Saturate at all-ones.
  - Reset to 0 asynchronously.
  - Not incremented while rst=1.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-DROP: drive br_taken=1 with im_stall=1 to enter DROP, assert rst → drop_pend=0, all enables 0 during reset; after release, idle inputs give all enables 1 and fsm=RUN.
- hz_stall=1 for 1 cycle, others 0 → pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1; next cycle all enables 1.
- br_taken=1, br_target=0x0000_0100, im_stall=0 → same cycle pc_redirect=1, pc_redirect_addr=0x100, pc_write=1, if_id_flush=1, id_ex_flush=1; hz_stall=1 simultaneously gives the same result.
- br_taken=1, target 0x200, im_stall=1 for 3 cycles → drop_pend=1 from the next cycle, pc_write=0 throughout; the cycle im_stall falls gives pc_redirect=1, addr 0x200, if_id_flush=1; the following cycle has drop_pend=0.
- In DROP, im_stall falls while dm_stall=1 for 2 cycles → no redirect, all writes 0; redirect to the pending address fires on the first cycle dm_stall=0.
- dm_stall=1 for 4 cycles with hz_stall=1 and br_taken=1 → all writes 0, no flush, fsm unchanged; with PIPE_PERF_CNT_EN, perf_dm_cyc increments by 4.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges hazard, branch, IM and DM waits.
// Define PIPE_PERF_CNT_EN to add saturating stall/redirect performance counters.
module pipe_stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hz_stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              im_stall,
  input  logic              dm_stall,
  output logic              pc_write,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_write,
  output logic              drop_pend
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_dm_cyc,
  output logic [CNT_W-1:0]  perf_im_cyc,
  output logic [CNT_W-1:0]  perf_redirect
`endif
);

  typedef enum logic {RUN, DROP} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pend_addr;
  state_t            w_state_next;
  logic [ADDR_W-1:0] w_pend_next;

  always_comb begin
    pc_write         = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = (r_state == DROP) ? r_pend_addr : br_target;
    if_id_write      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_write      = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_write     = 1'b0;
    mem_wb_write     = 1'b0;
    drop_pend        = (r_state == DROP);
    w_state_next     = r_state;
    w_pend_next      = r_pend_addr;

    if (rst) begin
      pc_redirect_addr = '0;
      drop_pend        = 1'b0;
    end else if (!dm_stall) begin
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if (r_state == DROP) begin
        // Every fetch returning while a redirect waits is stale, so keep squashing IF/ID.
        if_id_flush = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        if (br_taken) begin
          id_ex_flush = 1'b1;
          w_pend_next = br_target;
        end else if (!im_stall) begin
          pc_write     = 1'b1;
          pc_redirect  = 1'b1;
          w_state_next = RUN;
        end
      end else if (br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        if (!im_stall) begin
          pc_write    = 1'b1;
          pc_redirect = 1'b1;
        end else begin
          w_pend_next  = br_target;
          w_state_next = DROP;
        end
      end else if (hz_stall) begin
        id_ex_write = 1'b1;
        id_ex_flush = 1'b1;
      end else if (im_stall) begin
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_write = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pend_addr <= w_pend_next;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_dm_cyc;
  logic [CNT_W-1:0] r_im_cyc;
  logic [CNT_W-1:0] r_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dm_cyc   <= '0;
      r_im_cyc   <= '0;
      r_redirect <= '0;
    end else begin
      if (dm_stall && !(&r_dm_cyc))
        r_dm_cyc <= r_dm_cyc + 1'b1;
      if (im_stall && !dm_stall && !(&r_im_cyc))
        r_im_cyc <= r_im_cyc + 1'b1;
      if (pc_redirect && !(&r_redirect))
        r_redirect <= r_redirect + 1'b1;
    end
  end

  assign perf_dm_cyc   = r_dm_cyc;
  assign perf_im_cyc   = r_im_cyc;
  assign perf_redirect = r_redirect;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: hand-computed control vectors checked mid-cycle.
// Control vector order: {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write, drop_pend}
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz_stall, br_taken, im_stall, dm_stall;
  logic [31:0] br_target;
  logic        pc_write, pc_redirect, if_id_write, if_id_flush;
  logic        id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write, drop_pend;
  logic [31:0] pc_redirect_addr;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_dm_cyc, perf_im_cyc, perf_redirect;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .hz_stall(hz_stall), .br_taken(br_taken), .br_target(br_target),
    .im_stall(im_stall), .dm_stall(dm_stall),
    .pc_write(pc_write), .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .drop_pend(drop_pend)
`ifdef PIPE_PERF_CNT_EN
    , .perf_dm_cyc(perf_dm_cyc), .perf_im_cyc(perf_im_cyc), .perf_redirect(perf_redirect)
`endif
  );

  wire [8:0] w_ctl = {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_write,
                      id_ex_flush, ex_mem_write, mem_wb_write, drop_pend};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic drive(input logic hz, input logic br, input logic [31:0] tgt,
                       input logic im, input logic dm);
    hz_stall  = hz;
    br_taken  = br;
    br_target = tgt;
    im_stall  = im;
    dm_stall  = dm;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] CTL_IDLE = 9'b1_0_1_0_1_0_1_1_0;
  localparam logic [8:0] CTL_ZERO = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] CTL_BR_W = 9'b0_0_1_1_1_1_1_1_0;
  localparam logic [8:0] CTL_DROP = 9'b0_0_1_1_1_0_1_1_1;
  localparam logic [8:0] CTL_DFIN = 9'b1_1_1_1_1_0_1_1_1;
  localparam logic [8:0] CTL_HZ   = 9'b0_0_0_0_1_1_1_1_0;

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    sample();
    check("reset_ctl", {23'd0, w_ctl}, {23'd0, CTL_ZERO});
    check("reset_addr", pc_redirect_addr, 32'h0);
    step();
    step();
    rst = 1'b0;

    // Enter DROP, then reset in the middle of it
    drive(0, 1, 32'h300, 1, 0);
    sample();
    check("drop_enter_ctl", {23'd0, w_ctl}, {23'd0, CTL_BR_W});
    step();
    drive(0, 0, 32'h0, 1, 0);
    sample();
    check("drop_wait_ctl", {23'd0, w_ctl}, {23'd0, CTL_DROP});
    check("drop_wait_addr", pc_redirect_addr, 32'h300);
    rst = 1'b1;
    sample();
    check("rst_mid_drop_ctl", {23'd0, w_ctl}, {23'd0, CTL_ZERO});
    step();
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0);
    sample();
    check("post_rst_idle", {23'd0, w_ctl}, {23'd0, CTL_IDLE});
`ifdef PIPE_PERF_CNT_EN
    check("perf_dm_after_rst", perf_dm_cyc, 32'd0);
`endif
    step();

    // Hazard stall for one cycle
    drive(1, 0, 32'h0, 0, 0);
    sample();
    check("hz_ctl", {23'd0, w_ctl}, {23'd0, CTL_HZ});
    step();
    drive(0, 0, 32'h0, 0, 0);
    sample();
    check("hz_release", {23'd0, w_ctl}, {23'd0, CTL_IDLE});
    step();

    // Hazard wins over im_stall for IF/ID; im_stall alone bubbles ID
    drive(1, 0, 32'h0, 1, 0);
    sample();
    check("hz_im_ctl", {23'd0, w_ctl}, {23'd0, CTL_HZ});
    step();
    drive(0, 0, 32'h0, 1, 0);
    sample();
    check("im_only_ctl", {23'd0, w_ctl}, {23'd0, 9'b0_0_1_1_1_0_1_1_0});
    step();

    // Immediate branch redirect, without and with hz_stall
    drive(0, 1, 32'h100, 0, 0);
    sample();
    check("br_imm_ctl", {23'd0, w_ctl}, {23'd0, 9'b1_1_1_1_1_1_1_1_0});
    check("br_imm_addr", pc_redirect_addr, 32'h100);
    step();
    drive(1, 1, 32'h100, 0, 0);
    sample();
    check("br_hz_ctl", {23'd0, w_ctl}, {23'd0, 9'b1_1_1_1_1_1_1_1_0});
    check("br_hz_addr", pc_redirect_addr, 32'h100);
    step();

    // Branch collides with 3-cycle fetch
    drive(0, 1, 32'h200, 1, 0);
    sample();
    check("br_im_ctl", {23'd0, w_ctl}, {23'd0, CTL_BR_W});
    step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 1, 0);
      sample();
      check("drop_hold_ctl", {23'd0, w_ctl}, {23'd0, CTL_DROP});
      check("drop_hold_addr", pc_redirect_addr, 32'h200);
      step();
    end
    drive(0, 0, 32'h0, 0, 0);
    sample();
    check("drop_fire_ctl", {23'd0, w_ctl}, {23'd0, CTL_DFIN});
    check("drop_fire_addr", pc_redirect_addr, 32'h200);
    step();
    sample();
    check("drop_done_ctl", {23'd0, w_ctl}, {23'd0, CTL_IDLE});
    step();

    // Fetch returns during a DM freeze: redirect deferred
    drive(0, 1, 32'h400, 1, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 0, 1);
      sample();
      check("drop_dm_ctl", {23'd0, w_ctl}, {23'd0, 9'b0_0_0_0_0_0_0_0_1});
      step();
    end
    drive(0, 0, 32'h0, 0, 0);
    sample();
    check("drop_dm_fire_ctl", {23'd0, w_ctl}, {23'd0, CTL_DFIN});
    check("drop_dm_fire_addr", pc_redirect_addr, 32'h400);
    step();
`ifdef PIPE_PERF_CNT_EN
    sample();
    check("perf_dm_2", perf_dm_cyc, 32'd2);
`endif

    // Full freeze ignores hazard and branch
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h500, 0, 1);
      sample();
      check("dm_freeze_ctl", {23'd0, w_ctl}, {23'd0, CTL_ZERO});
      step();
    end
    drive(0, 0, 32'h0, 0, 0);
    sample();
    check("dm_unfreeze_ctl", {23'd0, w_ctl}, {23'd0, CTL_IDLE});
`ifdef PIPE_PERF_CNT_EN
    check("perf_dm_6", perf_dm_cyc, 32'd6);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
